// File: rtl/pc_sequencer.sv
// Program-counter sequencer: fetches one instruction word at a time and hands it to decode.
// Optional macro PC_WRAP_TRAP_EN turns out-of-range PC updates into a sticky trap with HALT.
module pc_sequencer #(
  parameter logic [17:0] RESET_PC = 18'h00000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        run,
  input  logic        halt_in,
  output logic        imem_req,
  output logic [17:0] imem_addr,
  input  logic        imem_ack,
  input  logic [17:0] imem_data,
  output logic        instr_valid,
  output logic [17:0] instr,
  input  logic        instr_ready,
  input  logic        br_taken,
  input  logic [13:0] br_off,
  output logic [17:0] pc,
  output logic        halted,
  output logic        trap
);

  typedef enum logic [1:0] {S_IDLE, S_FETCH, S_HOLD, S_HALT} state_t;

  state_t      state_q, state_d;
  logic [17:0] pc_q, pc_d;
  logic [17:0] instr_q, instr_d;
  state_t      after_accept;

`ifdef PC_WRAP_TRAP_EN
  logic        trap_q, trap_d;
  logic [19:0] pc_sum;
  logic        pc_ovf;

  // Unbounded sum: bit 19 set means it went negative, bit 18 means past 3FFFF.
  assign pc_sum = {2'b00, pc_q} + (br_taken ? {{6{br_off[13]}}, br_off} : 20'd1);
  assign pc_ovf = pc_sum[19] | pc_sum[18];
`else
  logic [17:0] pc_sum;

  assign pc_sum = pc_q + (br_taken ? {{4{br_off[13]}}, br_off} : 18'd1);
`endif

  always_comb begin
    after_accept = S_IDLE;
    if (halt_in)  after_accept = S_HALT;
    else if (run) after_accept = S_FETCH;
  end

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    instr_d = instr_q;
`ifdef PC_WRAP_TRAP_EN
    trap_d  = trap_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (halt_in)  state_d = S_HALT;
        else if (run) state_d = S_FETCH;
      end
      S_FETCH: begin
        // halt abandons the outstanding fetch even if the ack lands this cycle
        if (halt_in) state_d = S_HALT;
        else if (imem_ack) begin
          instr_d = imem_data;
          state_d = S_HOLD;
        end
      end
      S_HOLD: begin
        if (instr_ready) begin
`ifdef PC_WRAP_TRAP_EN
          if (pc_ovf) begin
            trap_d  = 1'b1;
            state_d = S_HALT;
          end else begin
            pc_d    = pc_sum[17:0];
            state_d = after_accept;
          end
`else
          pc_d    = pc_sum;
          state_d = after_accept;
`endif
        end
      end
      default: state_d = S_HALT;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      pc_q    <= RESET_PC;
      instr_q <= '0;
`ifdef PC_WRAP_TRAP_EN
      trap_q  <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      instr_q <= instr_d;
`ifdef PC_WRAP_TRAP_EN
      trap_q  <= trap_d;
`endif
    end
  end

  assign imem_req    = (state_q == S_FETCH);
  assign imem_addr   = pc_q;
  assign instr_valid = (state_q == S_HOLD);
  assign instr       = instr_q;
  assign pc          = pc_q;
  assign halted      = (state_q == S_HALT);
`ifdef PC_WRAP_TRAP_EN
  assign trap        = trap_q;
`else
  assign trap        = 1'b0;
`endif

endmodule

// File: tb/tb_pc_sequencer.sv
// Self-checking bench for pc_sequencer: directed scenarios plus a randomized run
// checked against an integer PC model.
module tb_pc_sequencer;
  logic        clk = 1'b0;
  logic        rst, run, halt_in, imem_req, imem_ack, instr_valid, instr_ready;
  logic        br_taken, halted, trap;
  logic [17:0] imem_addr, imem_data, instr, pc;
  logic [13:0] br_off;

  int     errors = 0;
  int     checks = 0;
  longint mpc;
  logic   exp_halt, exp_trap;

  always #5 clk = ~clk;

  pc_sequencer dut (
    .clk(clk), .rst(rst), .run(run), .halt_in(halt_in),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack), .imem_data(imem_data),
    .instr_valid(instr_valid), .instr(instr), .instr_ready(instr_ready),
    .br_taken(br_taken), .br_off(br_off), .pc(pc), .halted(halted), .trap(trap)
  );

  task automatic do_reset();
    rst = 1'b1; run = 1'b0; halt_in = 1'b0; imem_ack = 1'b0; instr_ready = 1'b0;
    br_taken = 1'b0; br_off = '0; imem_data = '0;
    @(negedge clk); @(negedge clk);
    rst = 1'b0;
    mpc = 0; exp_halt = 1'b0; exp_trap = 1'b0;
  endtask

  // One complete instruction: wait for request, ack after ack_dly, accept after rdy_dly.
  task automatic fetch_one(input int ack_dly, input logic [17:0] data, input int rdy_dly,
                           input logic br, input logic [13:0] off, input logic hlt,
                           input logic run_after);
    longint nxt;
    int     s;
    run = 1'b1; halt_in = 1'b0; instr_ready = 1'b0; imem_ack = 1'b0;
    for (int i = 0; i < 4 && !imem_req; i++) @(negedge clk);
    checks++;
    if (imem_req !== 1'b1) begin
      errors++; $display("FAIL fetch_req_timeout got=%b exp=1", imem_req);
      return;
    end
    checks++;
    if (imem_addr !== mpc[17:0] || pc !== mpc[17:0]) begin
      errors++; $display("FAIL fetch_addr got=%h/%h exp=%h", imem_addr, pc, mpc[17:0]);
    end
    for (int i = 0; i < ack_dly; i++) begin
      br_taken = 1'($urandom); br_off = 14'($urandom);
      @(negedge clk);
      checks++;
      if (imem_req !== 1'b1 || imem_addr !== mpc[17:0]) begin
        errors++; $display("FAIL fetch_stable got=%b/%h exp=1/%h", imem_req, imem_addr, mpc[17:0]);
      end
    end
    imem_ack = 1'b1; imem_data = data;
    @(negedge clk);
    imem_ack = 1'b0; imem_data = 18'($urandom);
    checks++;
    if (instr_valid !== 1'b1 || instr !== data) begin
      errors++; $display("FAIL instr_latch got=%b/%h exp=1/%h", instr_valid, instr, data);
    end
    for (int i = 0; i < rdy_dly; i++) begin
      br_taken = 1'($urandom); br_off = 14'($urandom);
      imem_ack = 1'($urandom); imem_data = 18'($urandom);
      @(negedge clk);
      checks++;
      if (instr_valid !== 1'b1 || instr !== data || pc !== mpc[17:0]) begin
        errors++; $display("FAIL hold_stable got=%b/%h/%h exp=1/%h/%h",
                           instr_valid, instr, pc, data, mpc[17:0]);
      end
    end
    imem_ack = 1'b0;
    instr_ready = 1'b1; br_taken = br; br_off = off; halt_in = hlt; run = run_after;
    @(negedge clk);
    instr_ready = 1'b0; br_taken = 1'b0; halt_in = 1'b0;
    s   = $signed(off);
    nxt = br ? mpc + s : mpc + 1;
`ifdef PC_WRAP_TRAP_EN
    if (nxt < 0 || nxt > 64'h3FFFF) begin
      exp_trap = 1'b1; exp_halt = 1'b1;
    end else mpc = nxt;
`else
    mpc = nxt & 64'h3FFFF;
`endif
    if (hlt) exp_halt = 1'b1;
    checks++;
    if (pc !== mpc[17:0] || halted !== exp_halt || trap !== exp_trap || instr_valid !== 1'b0 ||
        imem_req !== (!exp_halt && run_after)) begin
      errors++;
      $display("FAIL accept pc=%h halt=%b trap=%b vld=%b req=%b exp pc=%h halt=%b trap=%b vld=0 req=%b",
               pc, halted, trap, instr_valid, imem_req, mpc[17:0], exp_halt, exp_trap,
               !exp_halt && run_after);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; run = 1'b1; halt_in = 1'b0; imem_ack = 1'b1; instr_ready = 1'b1;
    br_taken = 1'b0; br_off = '0; imem_data = 18'h2AAAA;
    @(negedge clk); @(negedge clk);
    checks++;
    if (imem_req !== 1'b0 || instr_valid !== 1'b0 || halted !== 1'b0 || trap !== 1'b0) begin
      errors++; $display("FAIL reset_flags got req=%b vld=%b halt=%b trap=%b exp=0000",
                         imem_req, instr_valid, halted, trap);
    end
    checks++;
    if (pc !== 18'h0 || imem_addr !== 18'h0 || instr !== 18'h0) begin
      errors++; $display("FAIL reset_values got pc=%h addr=%h instr=%h exp=0", pc, imem_addr, instr);
    end
    do_reset();
    repeat (2) @(negedge clk);
    checks++;
    if (imem_req !== 1'b0 || pc !== 18'h0) begin
      errors++; $display("FAIL idle_stays got req=%b pc=%h exp=0/0", imem_req, pc);
    end
  endtask

  task automatic test_sequential();
    do_reset();
    for (int i = 0; i < 3; i++) fetch_one(0, 18'(i + 18'h100), 0, 1'b0, '0, 1'b0, 1'b1);
    checks++;
    if (imem_addr !== 18'h00003) begin
      errors++; $display("FAIL seq_addr got=%h exp=00003", imem_addr);
    end
  endtask

  task automatic test_branch();
    do_reset();
    fetch_one(0, 18'h1, 0, 1'b1, 14'h0010, 1'b0, 1'b1);
    fetch_one(0, 18'h2, 0, 1'b1, 14'h3FFC, 1'b0, 1'b1);
    checks++;
    if (imem_addr !== 18'h0000C) begin
      errors++; $display("FAIL branch_back got=%h exp=0000C", imem_addr);
    end
    fetch_one(0, 18'h3, 0, 1'b1, 14'h0004, 1'b0, 1'b1);
    fetch_one(0, 18'h4, 0, 1'b1, 14'h0005, 1'b0, 1'b1);
    checks++;
    if (imem_addr !== 18'h00015) begin
      errors++; $display("FAIL branch_fwd got=%h exp=00015", imem_addr);
    end
  endtask

  task automatic test_hold();
    do_reset();
    fetch_one(1, 18'h3C3C3, 5, 1'b0, '0, 1'b0, 1'b1);
    checks++;
    if (pc !== 18'h00001) begin
      errors++; $display("FAIL hold_pc got=%h exp=00001", pc);
    end
  endtask

  task automatic test_halt();
    do_reset();
    for (int i = 0; i < 4; i++) fetch_one(0, 18'(i), 0, 1'b0, '0, 1'b0, 1'b1);
    fetch_one(0, 18'h55, 0, 1'b0, '0, 1'b1, 1'b1);
    for (int i = 0; i < 6; i++) begin
      run = 1'b1; imem_ack = 1'($urandom); instr_ready = 1'($urandom);
      @(negedge clk);
      checks++;
      if (imem_req !== 1'b0 || halted !== 1'b1 || pc !== 18'h00005) begin
        errors++; $display("FAIL halt_sticky got req=%b halt=%b pc=%h exp=0/1/00005",
                           imem_req, halted, pc);
      end
    end
    do_reset();
    checks++;
    if (halted !== 1'b0 || pc !== 18'h0) begin
      errors++; $display("FAIL halt_exit got halt=%b pc=%h exp=0/0", halted, pc);
    end
    halt_in = 1'b1; run = 1'b1;
    @(negedge clk);
    halt_in = 1'b0;
    checks++;
    if (halted !== 1'b1 || imem_req !== 1'b0) begin
      errors++; $display("FAIL idle_halt got halt=%b req=%b exp=1/0", halted, imem_req);
    end
    do_reset();
    run = 1'b1;
    @(negedge clk);
    halt_in = 1'b1; imem_ack = 1'b1; imem_data = 18'h12345;
    @(negedge clk);
    halt_in = 1'b0; imem_ack = 1'b0;
    checks++;
    if (halted !== 1'b1 || instr_valid !== 1'b0 || instr !== 18'h0 || imem_req !== 1'b0) begin
      errors++; $display("FAIL fetch_halt got halt=%b vld=%b instr=%h req=%b exp=1/0/0/0",
                         halted, instr_valid, instr, imem_req);
    end
  endtask

  task automatic test_wrap();
    do_reset();
    for (int i = 0; i < 32; i++) fetch_one(0, 18'(i), 0, 1'b1, 14'h1FFF, 1'b0, 1'b1);
    fetch_one(0, 18'h7, 0, 1'b1, 14'd31, 1'b0, 1'b1);
    checks++;
    if (pc !== 18'h3FFFF) begin
      errors++; $display("FAIL wrap_setup got=%h exp=3FFFF", pc);
    end
    fetch_one(0, 18'h8, 0, 1'b0, '0, 1'b0, 1'b1);
`ifdef PC_WRAP_TRAP_EN
    checks++;
    if (trap !== 1'b1 || halted !== 1'b1 || pc !== 18'h3FFFF) begin
      errors++; $display("FAIL wrap_trap got trap=%b halt=%b pc=%h exp=1/1/3FFFF", trap, halted, pc);
    end
    do_reset();
    fetch_one(0, 18'h9, 0, 1'b1, 14'h3FFF, 1'b0, 1'b1);
    checks++;
    if (trap !== 1'b1 || pc !== 18'h0) begin
      errors++; $display("FAIL borrow_trap got trap=%b pc=%h exp=1/00000", trap, pc);
    end
`else
    checks++;
    if (pc !== 18'h0 || imem_req !== 1'b1 || trap !== 1'b0) begin
      errors++; $display("FAIL wrap_pc got pc=%h req=%b trap=%b exp=00000/1/0", pc, imem_req, trap);
    end
    fetch_one(0, 18'h9, 0, 1'b1, 14'h3FFF, 1'b0, 1'b1);
    checks++;
    if (pc !== 18'h3FFFF) begin
      errors++; $display("FAIL wrap_borrow got=%h exp=3FFFF", pc);
    end
`endif
  endtask

  task automatic test_reset_mid();
    do_reset();
    for (int i = 0; i < 3; i++) fetch_one(0, 18'(i), 0, 1'b0, '0, 1'b0, 1'b1);
    rst = 1'b1; imem_ack = 1'b1; imem_data = 18'h3ABCD;
    @(negedge clk);
    rst = 1'b0; imem_ack = 1'b0;
    checks++;
    if (imem_req !== 1'b0 || instr_valid !== 1'b0 || pc !== 18'h0 || instr !== 18'h0) begin
      errors++; $display("FAIL rst_fetch got req=%b vld=%b pc=%h instr=%h exp=0/0/0/0",
                         imem_req, instr_valid, pc, instr);
    end
    mpc = 0;
    for (int i = 0; i < 2; i++) fetch_one(0, 18'(i), 0, 1'b0, '0, 1'b0, 1'b1);
    imem_ack = 1'b1; imem_data = 18'h11111;
    @(negedge clk);
    imem_ack = 1'b0;
    rst = 1'b1; instr_ready = 1'b1; br_taken = 1'b1; br_off = 14'h0100;
    @(negedge clk);
    rst = 1'b0; instr_ready = 1'b0; br_taken = 1'b0; run = 1'b0;
    checks++;
    if (instr_valid !== 1'b0 || pc !== 18'h0 || imem_req !== 1'b0) begin
      errors++; $display("FAIL rst_hold got vld=%b pc=%h req=%b exp=0/0/0", instr_valid, pc, imem_req);
    end
    mpc = 0; exp_halt = 1'b0; exp_trap = 1'b0;
  endtask

  task automatic test_idle_ack();
    do_reset();
    fetch_one(0, 18'h5, 0, 1'b0, '0, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      imem_ack = 1'b1; imem_data = 18'($urandom); instr_ready = 1'b1;
      @(negedge clk);
      checks++;
      if (imem_req !== 1'b0 || instr_valid !== 1'b0 || pc !== 18'h00001 || instr !== 18'h5) begin
        errors++; $display("FAIL idle_ack got req=%b vld=%b pc=%h instr=%h exp=0/0/00001/00005",
                           imem_req, instr_valid, pc, instr);
      end
    end
    imem_ack = 1'b0; instr_ready = 1'b0;
    fetch_one(2, 18'h6, 1, 1'b0, '0, 1'b0, 1'b1);
  endtask

  task automatic test_random();
    int s, lo;
    do_reset();
    for (int n = 0; n < 60; n++) begin
      logic br;
      br = 1'($urandom);
      lo = (mpc < 200) ? int'(mpc) : 200;
      s  = $urandom_range(lo + 200, 0) - lo;
      fetch_one($urandom_range(3, 0), 18'($urandom), $urandom_range(3, 0), br, 14'(s),
                1'b0, ($urandom_range(3, 0) != 0));
    end
  endtask

  initial begin
    test_reset();
    test_sequential();
    test_branch();
    test_hold();
    test_halt();
    test_wrap();
    test_reset_mid();
    test_idle_ack();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout got=running exp=finished");
    $fatal(1, "timeout");
  end
endmodule
